ctrl_pipe_unit: RTL and testbench

- Registered, exception-aware successor to the combinational opcode decoder.
- Decodes the 5-bit opcode in ID into the full control bundle and registers it into the ID/EX boundary.
- Applies stall/flush/memory-busy, owns a trap state machine (SIIC/RTI with EPC) and a sticky halt.
- Sits between fetch/decode and the execute stage; hazard and branch units drive stall/flush.

---
 rtl/ctrl_pkg.sv | 89 ++++++++
 rtl/ctrl_pipe_unit_decode.sv | 118 +++++++++++
 rtl/ctrl_pipe_unit.sv | 160 ++++++++++++++++
 tb/tb_ctrl_pipe_unit.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the registered control pipeline unit.
// Contents: opcode encodings, immediate/destination/link encodings,
// trap FSM state encoding, the packed ID/EX control bundle and a
// helper returning the NOP bubble bundle.
package ctrl_pkg;

    localparam int CTRL_OPC_W = 5;

    localparam logic [4:0] OP_HALT  = 5'b00000;
    localparam logic [4:0] OP_NOP   = 5'b00001;
    localparam logic [4:0] OP_SIIC  = 5'b00010;
    localparam logic [4:0] OP_RTI   = 5'b00011;
    localparam logic [4:0] OP_J     = 5'b00100;
    localparam logic [4:0] OP_JR    = 5'b00101;
    localparam logic [4:0] OP_JAL   = 5'b00110;
    localparam logic [4:0] OP_JALR  = 5'b00111;
    localparam logic [4:0] OP_ADDI  = 5'b01000;
    localparam logic [4:0] OP_SUBI  = 5'b01001;
    localparam logic [4:0] OP_XORI  = 5'b01010;
    localparam logic [4:0] OP_ANDNI = 5'b01011;
    localparam logic [4:0] OP_BEQZ  = 5'b01100;
    localparam logic [4:0] OP_BNEZ  = 5'b01101;
    localparam logic [4:0] OP_BLTZ  = 5'b01110;
    localparam logic [4:0] OP_BGEZ  = 5'b01111;
    localparam logic [4:0] OP_ST    = 5'b10000;
    localparam logic [4:0] OP_LD    = 5'b10001;
    localparam logic [4:0] OP_SLBI  = 5'b10010;
    localparam logic [4:0] OP_STU   = 5'b10011;
    localparam logic [4:0] OP_ROLI  = 5'b10100;
    localparam logic [4:0] OP_SLLI  = 5'b10101;
    localparam logic [4:0] OP_RORI  = 5'b10110;
    localparam logic [4:0] OP_SRLI  = 5'b10111;
    localparam logic [4:0] OP_LBI   = 5'b11000;
    localparam logic [4:0] OP_BTR   = 5'b11001;
    localparam logic [4:0] OP_ALU1  = 5'b11010;
    localparam logic [4:0] OP_ALU2  = 5'b11011;
    localparam logic [4:0] OP_SEQ   = 5'b11100;
    localparam logic [4:0] OP_SLT   = 5'b11101;
    localparam logic [4:0] OP_SLE   = 5'b11110;
    localparam logic [4:0] OP_SCO   = 5'b11111;

    // imm_sel = {sign, size}
    localparam logic [2:0] IMM_Z5  = 3'b000;
    localparam logic [2:0] IMM_Z8  = 3'b001;
    localparam logic [2:0] IMM_S5  = 3'b100;
    localparam logic [2:0] IMM_S8  = 3'b101;
    localparam logic [2:0] IMM_S11 = 3'b110;

    localparam logic [1:0] DEST_RS   = 2'b00;
    localparam logic [1:0] DEST_RD_R = 2'b01;
    localparam logic [1:0] DEST_R7   = 2'b10;
    localparam logic [1:0] DEST_RD_I = 2'b11;

    localparam logic [1:0] LINK_NONE = 2'b00;
    localparam logic [1:0] LINK_LBI  = 2'b01;
    localparam logic [1:0] LINK_PC   = 2'b10;

    localparam logic [4:0] NOP_ALU = 5'b00001;
    localparam logic [4:0] ADR_ALU = 5'b01000;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_TRAP   = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    typedef struct packed {
        logic       reg_write;
        logic       pc_sel;
        logic       reg_jmp;
        logic       mem_en;
        logic       mem_wr;
        logic       val2reg;
        logic       alu_sel;
        logic       b_flag;
        logic [1:0] dest_reg_sel;
        logic [1:0] link_reg;
        logic [2:0] imm_sel;
        logic [4:0] alu_cntrl;
    } ctrl_t;

    function automatic ctrl_t bubble_ctrl();
        ctrl_t c;
        c           = '0;
        c.alu_cntrl = NOP_ALU;
        return c;
    endfunction

endpackage

// File: rtl/ctrl_pipe_unit_decode.sv
// Purely combinational opcode -> control bundle decode.
// Ports: opcode_i (5-bit opcode from ID), ctrl_o (decoded bundle).
// HALT/NOP/SIIC/RTI decode to the bubble; their side effects live in
// the trap state machine of ctrl_pipe_unit.
module ctrl_pipe_unit_decode
    import ctrl_pkg::*;
(
    input  logic [CTRL_OPC_W-1:0] opcode_i,
    output ctrl_t                 ctrl_o
);

    ctrl_t c;

    always_comb begin
        c = bubble_ctrl();
        case (opcode_i)
            OP_J: begin
                c.pc_sel    = 1'b1;
                c.imm_sel   = IMM_S11;
                c.link_reg  = LINK_PC;
                c.alu_cntrl = ADR_ALU;
            end
            OP_JR: begin
                c.reg_jmp   = 1'b1;
                c.alu_sel   = 1'b1;
                c.imm_sel   = IMM_S8;
                c.link_reg  = LINK_PC;
                c.alu_cntrl = ADR_ALU;
            end
            OP_JAL: begin
                c.pc_sel       = 1'b1;
                c.reg_write    = 1'b1;
                c.dest_reg_sel = DEST_R7;
                c.imm_sel      = IMM_S11;
                c.link_reg     = LINK_PC;
                c.alu_cntrl    = ADR_ALU;
            end
            OP_JALR: begin
                c.reg_jmp      = 1'b1;
                c.reg_write    = 1'b1;
                c.alu_sel      = 1'b1;
                c.dest_reg_sel = DEST_R7;
                c.imm_sel      = IMM_S8;
                c.link_reg     = LINK_PC;
                c.alu_cntrl    = ADR_ALU;
            end
            OP_ADDI, OP_SUBI: begin
                c.reg_write    = 1'b1;
                c.alu_sel      = 1'b1;
                c.dest_reg_sel = DEST_RD_I;
                c.imm_sel      = IMM_S5;
                c.alu_cntrl    = opcode_i;
            end
            OP_XORI, OP_ANDNI, OP_ROLI, OP_SLLI, OP_RORI, OP_SRLI: begin
                c.reg_write    = 1'b1;
                c.alu_sel      = 1'b1;
                c.dest_reg_sel = DEST_RD_I;
                c.imm_sel      = IMM_Z5;
                c.alu_cntrl    = opcode_i;
            end
            OP_BEQZ, OP_BNEZ, OP_BLTZ, OP_BGEZ: begin
                c.b_flag    = 1'b1;
                c.imm_sel   = IMM_S8;
                c.alu_cntrl = opcode_i;
            end
            OP_ST: begin
                c.mem_en    = 1'b1;
                c.mem_wr    = 1'b1;
                c.alu_sel   = 1'b1;
                c.imm_sel   = IMM_S5;
                c.alu_cntrl = ADR_ALU;
            end
            OP_LD: begin
                c.mem_en       = 1'b1;
                c.val2reg      = 1'b1;
                c.reg_write    = 1'b1;
                c.alu_sel      = 1'b1;
                c.dest_reg_sel = DEST_RD_I;
                c.imm_sel      = IMM_S5;
                c.alu_cntrl    = ADR_ALU;
            end
            OP_STU: begin
                // store with base-register update: writes the address back to Rs
                c.mem_en       = 1'b1;
                c.mem_wr       = 1'b1;
                c.reg_write    = 1'b1;
                c.alu_sel      = 1'b1;
                c.dest_reg_sel = DEST_RS;
                c.imm_sel      = IMM_S5;
                c.alu_cntrl    = ADR_ALU;
            end
            OP_SLBI: begin
                c.reg_write    = 1'b1;
                c.alu_sel      = 1'b1;
                c.dest_reg_sel = DEST_RS;
                c.imm_sel      = IMM_Z8;
                c.alu_cntrl    = opcode_i;
            end
            OP_LBI: begin
                c.reg_write    = 1'b1;
                c.alu_sel      = 1'b1;
                c.dest_reg_sel = DEST_RS;
                c.link_reg     = LINK_LBI;
                c.imm_sel      = IMM_S8;
                c.alu_cntrl    = opcode_i;
            end
            OP_BTR, OP_ALU1, OP_ALU2, OP_SEQ, OP_SLT, OP_SLE, OP_SCO: begin
                c.reg_write    = 1'b1;
                c.dest_reg_sel = DEST_RD_R;
                c.alu_cntrl    = opcode_i;
            end
            default: ;
        endcase
    end

    assign ctrl_o = c;

endmodule

// File: rtl/ctrl_pipe_unit.sv
// ID/EX control register with stall/flush handling, trap FSM and sticky halt.
// Ports: clk/rst_n; ID side id_valid, opcode, pc_plus2; hazard inputs
// stall, mem_busy, flush; registered bundle (ex_valid + control bits);
// exception outputs exc_redirect, exc_target, epc, in_trap, halt, rti_err.
//
// state   | meaning
// RUN     | normal execution
// TRAP    | inside the SIIC handler, epc holds the return address
// HALTED  | HALT or fatal fault seen; only reset leaves this state
module ctrl_pipe_unit
    import ctrl_pkg::*;
#(
    parameter int              PC_W                   = 16,
    parameter int              OPC_W                  = 5,
    parameter logic [PC_W-1:0] HANDLER_ADDR           = 16'h0002,
    parameter int              RTI_OUTSIDE_TRAP_HALTS = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [OPC_W-1:0] opcode,
    input  logic [PC_W-1:0]  pc_plus2,
    input  logic             stall,
    input  logic             mem_busy,
    input  logic             flush,
    output logic             ex_valid,
    output logic             reg_write,
    output logic             pc_sel,
    output logic             reg_jmp,
    output logic             mem_en,
    output logic             mem_wr,
    output logic             val2reg,
    output logic             alu_sel,
    output logic             b_flag,
    output logic [1:0]       dest_reg_sel,
    output logic [1:0]       link_reg,
    output logic [2:0]       imm_sel,
    output logic [OPC_W-1:0] alu_cntrl,
    output logic             exc_redirect,
    output logic [PC_W-1:0]  exc_target,
    output logic [PC_W-1:0]  epc,
    output logic             in_trap,
    output logic             halt,
    output logic             rti_err
);

    ctrl_t            dec_ctrl;
    ctrl_t            ctrl_q, ctrl_d;
    state_e           state_q, state_d;
    logic             ex_valid_q, ex_valid_d;
    logic             redirect_q, redirect_d;
    logic [PC_W-1:0]  target_q, target_d;
    logic [PC_W-1:0]  epc_q, epc_d;
    logic             rti_err_q, rti_err_d;

    ctrl_pipe_unit_decode u_decode (
        .opcode_i (opcode),
        .ctrl_o   (dec_ctrl)
    );

    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        ex_valid_d = ex_valid_q;
        target_d   = target_q;
        epc_d      = epc_q;
        redirect_d = 1'b0;
        rti_err_d  = 1'b0;

        if (state_q == ST_HALTED) begin
            ctrl_d     = bubble_ctrl();
            ex_valid_d = 1'b0;
        end else if (flush) begin
            ctrl_d     = bubble_ctrl();
            ex_valid_d = 1'b0;
        end else if (stall || mem_busy) begin
            // hold the bundle; pulses still drop so they never stretch
        end else if (!id_valid) begin
            ctrl_d     = bubble_ctrl();
            ex_valid_d = 1'b0;
        end else begin
            ctrl_d     = dec_ctrl;
            ex_valid_d = 1'b1;
            case (opcode)
                OP_SIIC: begin
                    ctrl_d     = bubble_ctrl();
                    ex_valid_d = 1'b0;
                    if (state_q == ST_RUN) begin
                        epc_d      = pc_plus2;
                        target_d   = HANDLER_ADDR;
                        redirect_d = 1'b1;
                        state_d    = ST_TRAP;
                    end else begin
                        state_d = ST_HALTED;
                    end
                end
                OP_RTI: begin
                    ctrl_d     = bubble_ctrl();
                    ex_valid_d = 1'b0;
                    if (state_q == ST_TRAP) begin
                        target_d   = epc_q;
                        redirect_d = 1'b1;
                        state_d    = ST_RUN;
                    end else if (RTI_OUTSIDE_TRAP_HALTS != 0) begin
                        state_d = ST_HALTED;
                    end else begin
                        rti_err_d = 1'b1;
                    end
                end
                OP_HALT: begin
                    ctrl_d     = bubble_ctrl();
                    ex_valid_d = 1'b0;
                    state_d    = ST_HALTED;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            ctrl_q     <= bubble_ctrl();
            ex_valid_q <= 1'b0;
            redirect_q <= 1'b0;
            target_q   <= '0;
            epc_q      <= '0;
            rti_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            ex_valid_q <= ex_valid_d;
            redirect_q <= redirect_d;
            target_q   <= target_d;
            epc_q      <= epc_d;
            rti_err_q  <= rti_err_d;
        end
    end

    assign ex_valid     = ex_valid_q;
    assign reg_write    = ctrl_q.reg_write;
    assign pc_sel       = ctrl_q.pc_sel;
    assign reg_jmp      = ctrl_q.reg_jmp;
    assign mem_en       = ctrl_q.mem_en;
    assign mem_wr       = ctrl_q.mem_wr;
    assign val2reg      = ctrl_q.val2reg;
    assign alu_sel      = ctrl_q.alu_sel;
    assign b_flag       = ctrl_q.b_flag;
    assign dest_reg_sel = ctrl_q.dest_reg_sel;
    assign link_reg     = ctrl_q.link_reg;
    assign imm_sel      = ctrl_q.imm_sel;
    assign alu_cntrl    = ctrl_q.alu_cntrl;
    assign exc_redirect = redirect_q;
    assign exc_target   = target_q;
    assign epc          = epc_q;
    assign in_trap      = (state_q == ST_TRAP);
    assign halt         = (state_q == ST_HALTED);
    assign rti_err      = rti_err_q;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
module tb_ctrl_pipe_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  opcode;
    logic [15:0] pc_plus2;
    logic        stall, mem_busy, flush;

    logic        ev0, rw0, ps0, rj0, me0, mw0, v2r0, as0, bf0;
    logic [1:0]  dest0, link0;
    logic [2:0]  imm0;
    logic [4:0]  alu0;
    logic        redir0, trap0, halt0, rerr0;
    logic [15:0] tgt0, epc0;

    logic        ev1, rw1, ps1, rj1, me1, mw1, v2r1, as1, bf1;
    logic [1:0]  dest1, link1;
    logic [2:0]  imm1;
    logic [4:0]  alu1;
    logic        redir1, trap1, halt1, rerr1;
    logic [15:0] tgt1, epc1;

    always #5 clk = ~clk;

    ctrl_pipe_unit #(.RTI_OUTSIDE_TRAP_HALTS(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .opcode(opcode),
        .pc_plus2(pc_plus2), .stall(stall), .mem_busy(mem_busy), .flush(flush),
        .ex_valid(ev0), .reg_write(rw0), .pc_sel(ps0), .reg_jmp(rj0),
        .mem_en(me0), .mem_wr(mw0), .val2reg(v2r0), .alu_sel(as0), .b_flag(bf0),
        .dest_reg_sel(dest0), .link_reg(link0), .imm_sel(imm0), .alu_cntrl(alu0),
        .exc_redirect(redir0), .exc_target(tgt0), .epc(epc0), .in_trap(trap0),
        .halt(halt0), .rti_err(rerr0)
    );

    ctrl_pipe_unit #(.RTI_OUTSIDE_TRAP_HALTS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .opcode(opcode),
        .pc_plus2(pc_plus2), .stall(stall), .mem_busy(mem_busy), .flush(flush),
        .ex_valid(ev1), .reg_write(rw1), .pc_sel(ps1), .reg_jmp(rj1),
        .mem_en(me1), .mem_wr(mw1), .val2reg(v2r1), .alu_sel(as1), .b_flag(bf1),
        .dest_reg_sel(dest1), .link_reg(link1), .imm_sel(imm1), .alu_cntrl(alu1),
        .exc_redirect(redir1), .exc_target(tgt1), .epc(epc1), .in_trap(trap1),
        .halt(halt1), .rti_err(rerr1)
    );

    logic [20:0] ctl0, ctl1;
    assign ctl0 = {ev0, rw0, ps0, rj0, me0, mw0, v2r0, as0, bf0, dest0, link0, imm0, alu0};
    assign ctl1 = {ev1, rw1, ps1, rj1, me1, mw1, v2r1, as1, bf1, dest1, link1, imm1, alu1};

    typedef struct {
        logic        idv;
        logic [4:0]  opc;
        logic [15:0] pc;
        logic        stl, mbz, fl;
        logic [20:0] ctl;
        logic        redir;
        logic [15:0] tgt, epc;
        logic        trap, halt, rerr;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;
    vec_t vecs[$];

    function automatic logic [20:0] mk(input logic ev, rw, pcs, rj, me, mw, v2r, as, bf,
                                       input logic [1:0] dest, link,
                                       input logic [2:0] imm, input logic [4:0] alu);
        return {ev, rw, pcs, rj, me, mw, v2r, as, bf, dest, link, imm, alu};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic idv, input logic [4:0] opc, input logic [15:0] pc,
                       input logic stl, mbz, fl, input logic [20:0] ctl,
                       input logic redir, input logic [15:0] tgt, epc,
                       input logic trap, halt, rerr);
        vec_t v;
        v.idv = idv; v.opc = opc; v.pc = pc; v.stl = stl; v.mbz = mbz; v.fl = fl;
        v.ctl = ctl; v.redir = redir; v.tgt = tgt; v.epc = epc;
        v.trap = trap; v.halt = halt; v.rerr = rerr;
        vecs.push_back(v);
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        id_valid = v.idv; opcode = v.opc; pc_plus2 = v.pc;
        stall = v.stl; mem_busy = v.mbz; flush = v.fl;
        @(posedge clk);
        #1;
        chk({tag, " ctl"},      {11'd0, ctl0}, {11'd0, v.ctl});
        chk({tag, " redirect"}, {31'd0, redir0}, {31'd0, v.redir});
        chk({tag, " target"},   {16'd0, tgt0}, {16'd0, v.tgt});
        chk({tag, " epc"},      {16'd0, epc0}, {16'd0, v.epc});
        chk({tag, " in_trap"},  {31'd0, trap0}, {31'd0, v.trap});
        chk({tag, " halt"},     {31'd0, halt0}, {31'd0, v.halt});
        chk({tag, " rti_err"},  {31'd0, rerr0}, {31'd0, v.rerr});
    endtask

    logic [20:0] C_ADD, C_BUB, C_LD, C_ADDI, C_BEQZ, C_ST, C_JAL, C_LBI, C_SLBI;

    initial begin
        vec_t v;
        C_ADD  = mk(1,1,0,0,0,0,0,0,0, 2'b01, 2'b00, 3'b000, 5'b11011);
        C_BUB  = mk(0,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 3'b000, 5'b00001);
        C_LD   = mk(1,1,0,0,1,0,1,1,0, 2'b11, 2'b00, 3'b100, 5'b01000);
        C_ADDI = mk(1,1,0,0,0,0,0,1,0, 2'b11, 2'b00, 3'b100, 5'b01000);
        C_BEQZ = mk(1,0,0,0,0,0,0,0,1, 2'b00, 2'b00, 3'b101, 5'b01100);
        C_ST   = mk(1,0,0,0,1,1,0,1,0, 2'b00, 2'b00, 3'b100, 5'b01000);
        C_JAL  = mk(1,1,1,0,0,0,0,0,0, 2'b10, 2'b10, 3'b110, 5'b01000);
        C_LBI  = mk(1,1,0,0,0,0,0,1,0, 2'b00, 2'b01, 3'b101, 5'b11000);
        C_SLBI = mk(1,1,0,0,0,0,0,1,0, 2'b00, 2'b00, 3'b001, 5'b10010);

        //   idv opc       pc      stl mbz fl ctl     rd tgt      epc      trp hlt rer
        add(1, 5'b11011, 16'h0000, 0, 0, 0, C_ADD,  0, 16'h0000, 16'h0000, 0, 0, 0);
        add(1, 5'b10001, 16'h0000, 1, 0, 0, C_ADD,  0, 16'h0000, 16'h0000, 0, 0, 0);
        add(1, 5'b10001, 16'h0000, 1, 0, 0, C_ADD,  0, 16'h0000, 16'h0000, 0, 0, 0);
        add(1, 5'b10001, 16'h0000, 1, 0, 0, C_ADD,  0, 16'h0000, 16'h0000, 0, 0, 0);
        add(1, 5'b10001, 16'h0000, 0, 0, 0, C_LD,   0, 16'h0000, 16'h0000, 0, 0, 0);
        add(1, 5'b01000, 16'h0000, 0, 0, 0, C_ADDI, 0, 16'h0000, 16'h0000, 0, 0, 0);
        add(1, 5'b01100, 16'h0000, 0, 0, 0, C_BEQZ, 0, 16'h0000, 16'h0000, 0, 0, 0);
        add(1, 5'b10000, 16'h0000, 0, 1, 0, C_BEQZ, 0, 16'h0000, 16'h0000, 0, 0, 0);
        add(1, 5'b10000, 16'h0000, 0, 0, 0, C_ST,   0, 16'h0000, 16'h0000, 0, 0, 0);
        add(1, 5'b00110, 16'h0000, 0, 0, 0, C_JAL,  0, 16'h0000, 16'h0000, 0, 0, 0);
        add(1, 5'b11000, 16'h0000, 0, 0, 0, C_LBI,  0, 16'h0000, 16'h0000, 0, 0, 0);
        add(1, 5'b10010, 16'h0000, 0, 0, 0, C_SLBI, 0, 16'h0000, 16'h0000, 0, 0, 0);
        add(0, 5'b11011, 16'h0000, 0, 0, 0, C_BUB,  0, 16'h0000, 16'h0000, 0, 0, 0);
        add(1, 5'b11011, 16'h0000, 1, 0, 1, C_BUB,  0, 16'h0000, 16'h0000, 0, 0, 0);
        add(1, 5'b00010, 16'h0040, 1, 0, 1, C_BUB,  0, 16'h0000, 16'h0000, 0, 0, 0);
        add(1, 5'b00010, 16'h0040, 1, 0, 0, C_BUB,  0, 16'h0000, 16'h0000, 0, 0, 0);
        add(1, 5'b00010, 16'h0040, 0, 0, 0, C_BUB,  1, 16'h0002, 16'h0040, 1, 0, 0);
        add(1, 5'b11011, 16'h0050, 0, 0, 0, C_ADD,  0, 16'h0002, 16'h0040, 1, 0, 0);
        add(1, 5'b00011, 16'h0060, 0, 0, 0, C_BUB,  1, 16'h0040, 16'h0040, 0, 0, 0);
        add(1, 5'b00011, 16'h0070, 0, 0, 0, C_BUB,  0, 16'h0040, 16'h0040, 0, 0, 1);
        add(1, 5'b11011, 16'h0072, 0, 0, 0, C_ADD,  0, 16'h0040, 16'h0040, 0, 0, 0);
        add(1, 5'b00010, 16'h0080, 0, 0, 0, C_BUB,  1, 16'h0002, 16'h0080, 1, 0, 0);
        add(1, 5'b00010, 16'h0090, 0, 0, 0, C_BUB,  0, 16'h0002, 16'h0080, 0, 1, 0);
        add(1, 5'b11011, 16'h0092, 0, 0, 0, C_BUB,  0, 16'h0002, 16'h0080, 0, 1, 0);
        add(1, 5'b11011, 16'h0094, 1, 0, 0, C_BUB,  0, 16'h0002, 16'h0080, 0, 1, 0);

        rst_n = 1'b0; id_valid = 1'b0; opcode = 5'b0; pc_plus2 = 16'h0;
        stall = 1'b0; mem_busy = 1'b0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset ctl",      {11'd0, ctl0}, {11'd0, C_BUB});
        chk("reset redirect", {31'd0, redir0}, 32'd0);
        chk("reset target",   {16'd0, tgt0}, 32'd0);
        chk("reset epc",      {16'd0, epc0}, 32'd0);
        chk("reset state",    {29'd0, trap0, halt0, rerr0}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i], $sformatf("v%0d", i));

        // mode-1 instance saw the same stream and halted on RTI in RUN
        chk("mode1 halt",     {31'd0, halt1}, 32'd1);
        chk("mode1 ex_valid", {31'd0, ev1}, 32'd0);
        chk("mode1 rti_err",  {31'd0, rerr1}, 32'd0);
        chk("mode1 epc",      {16'd0, epc1}, 32'h0040);

        // asynchronous reset in the middle of a cycle clears halt and epc
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async halt",   {31'd0, halt0}, 32'd0);
        chk("async epc",    {16'd0, epc0}, 32'd0);
        chk("async target", {16'd0, tgt0}, 32'd0);
        chk("async ctl",    {11'd0, ctl0}, {11'd0, C_BUB});
        chk("async halt1",  {31'd0, halt1}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        v = vecs[0];
        apply(v, "post-reset add");
        v.opc = 5'b00000; v.ctl = C_BUB; v.halt = 1'b1;
        apply(v, "halt op");
        v.opc = 5'b11011; v.pc = 16'h0100;
        apply(v, "halted add");
        v.opc = 5'b00010;
        apply(v, "halted siic");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
